// File: rtl/usb_replay_pkg.sv
// usb_replay_pkg: shared types for the USB line-state replay controller.
package usb_replay_pkg;

  typedef enum logic [2:0] {
    IDLE,
    ATTACH,
    PLAY,
    PAUSE,
    DONE
  } replay_state_t;

  localparam logic [1:0] SE0 = 2'b00;

  typedef struct packed {
    logic last;
    logic dp;
    logic dn;
  } replay_entry_t;

endpackage

// File: rtl/usb_replay_fifo.sv
// usb_replay_fifo: synchronous sample FIFO, FIFO_DEPTH entries (power of two),
// combinational read of the head entry, flushed by RSTB.
module usb_replay_fifo
  import usb_replay_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH = 16
) (
  input  logic          clk_samp,
  input  logic          RSTB,
  input  logic          i_push,
  input  replay_entry_t i_wdata,
  input  logic          i_pop,
  output replay_entry_t o_rdata,
  output logic          o_full,
  output logic          o_empty
);

  localparam int unsigned AW = $clog2(FIFO_DEPTH);

  replay_entry_t r_mem [FIFO_DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [AW:0]   r_count;
  logic          w_do_push;
  logic          w_do_pop;

  assign o_empty   = (r_count == '0);
  assign o_full    = (r_count == (AW+1)'(FIFO_DEPTH));
  assign w_do_pop  = i_pop && !o_empty;
  // a pop frees the slot, so a full FIFO can still take a push in the same cycle
  assign w_do_push = i_push && (!o_full || w_do_pop);
  assign o_rdata   = r_mem[r_rd_ptr];

  // Sample storage; no reset needed since the pointers define validity.
  always_ff @(posedge clk_samp) begin
    if (w_do_push) r_mem[r_wr_ptr] <= i_wdata;
  end

  // Pointer and occupancy tracking; reset flushes the buffer.
  always_ff @(posedge clk_samp) begin
    if (RSTB) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + (AW+1)'(1);
        2'b01:   r_count <= r_count - (AW+1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/usb_replay_ctrl.sv
// usb_replay_ctrl: replays buffered D+/D- line-state samples onto the USB pads
// once the DUT pull-up has been attached for ATTACH_CYC cycles, one sample per
// DIV cycles, yielding the bus whenever the DUT drives it.
// Optional macro USB_REPLAY_UNDERRUN_CNT_EN adds a saturating underrun_cnt_o.
module usb_replay_ctrl
  import usb_replay_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH = 16,
  parameter int unsigned ATTACH_CYC = 1024,
  parameter int unsigned DIV        = 1
) (
  input  logic        clk_samp,
  input  logic        RSTB,
  input  logic        pu_i,
  input  logic [1:0]  dut_oeb_i,
  input  logic [7:0]  src_data_i,
  input  logic        src_valid_i,
  input  logic        src_last_i,
  output logic        src_ready_o,
  output logic        dp_o,
  output logic        dn_o,
  output logic        dp_oe_o,
  output logic        dn_oe_o,
  output logic        done_o,
  output logic [31:0] sample_cnt_o
`ifdef USB_REPLAY_UNDERRUN_CNT_EN
  ,
  output logic [15:0] underrun_cnt_o
`endif
);

  replay_state_t r_state;
  logic [31:0]   r_attach_cnt;
  logic [31:0]   r_div_cnt;
  logic [31:0]   r_sample_cnt;
  logic          r_last_seen;
  logic          r_dp;
  logic          r_dn;
  logic          r_done;
  logic          w_full;
  logic          w_empty;
  logic          w_push;
  logic          w_pop;
  logic          w_div_tc;
  logic          w_bus_free;
  logic          w_unused;
  replay_entry_t w_wdata;
  replay_entry_t w_rdata;
`ifdef USB_REPLAY_UNDERRUN_CNT_EN
  logic [15:0]   r_underrun_cnt;
  assign underrun_cnt_o = r_underrun_cnt;
`endif

  assign w_bus_free  = (dut_oeb_i == 2'b11);
  assign w_div_tc    = (r_div_cnt == DIV - 1);
  assign src_ready_o = !w_full && (r_state != DONE) && !r_last_seen;
  assign w_push      = src_valid_i && src_ready_o;
  assign w_wdata     = '{last: src_last_i, dp: src_data_i[1], dn: src_data_i[0]};
  assign w_pop       = (r_state == PLAY) && pu_i && w_bus_free && w_div_tc && !w_empty;
  assign w_unused    = ^src_data_i[7:2];

  assign dp_oe_o      = (r_state == PLAY) && dut_oeb_i[1];
  assign dn_oe_o      = (r_state == PLAY) && dut_oeb_i[0];
  assign dp_o         = r_dp;
  assign dn_o         = r_dn;
  assign done_o       = r_done;
  assign sample_cnt_o = r_sample_cnt;

  usb_replay_fifo #(
    .FIFO_DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk_samp (clk_samp),
    .RSTB     (RSTB),
    .i_push   (w_push),
    .i_wdata  (w_wdata),
    .i_pop    (w_pop),
    .o_rdata  (w_rdata),
    .o_full   (w_full),
    .o_empty  (w_empty)
  );

  // Playback sequencer with registered line values, done flag and counters.
  always_ff @(posedge clk_samp) begin
    if (RSTB) begin
      r_state      <= IDLE;
      r_attach_cnt <= '0;
      r_div_cnt    <= '0;
      r_sample_cnt <= '0;
      r_last_seen  <= 1'b0;
      {r_dp, r_dn} <= SE0;
      r_done       <= 1'b0;
`ifdef USB_REPLAY_UNDERRUN_CNT_EN
      r_underrun_cnt <= '0;
`endif
    end else begin
      if (w_push && src_last_i) r_last_seen <= 1'b1;
      case (r_state)
        IDLE: begin
          if (pu_i) begin
            r_attach_cnt <= ATTACH_CYC - 1;
            r_state      <= ATTACH;
          end
        end
        ATTACH: begin
          if (!pu_i) begin
            r_state <= IDLE;
          end else if (r_attach_cnt == '0) begin
            r_state   <= PLAY;
            r_div_cnt <= '0;
          end else begin
            r_attach_cnt <= r_attach_cnt - 32'd1;
          end
        end
        PLAY: begin
          // pull-up loss outranks DUT drive, which outranks the sample pop
          if (!pu_i) begin
            r_state <= IDLE;
          end else if (!w_bus_free) begin
            r_state <= PAUSE;
          end else if (w_div_tc) begin
            r_div_cnt <= '0;
            if (w_pop) begin
              r_dp         <= w_rdata.dp;
              r_dn         <= w_rdata.dn;
              r_sample_cnt <= r_sample_cnt + 32'd1;
              if (w_rdata.last) begin
                r_state <= DONE;
                r_done  <= 1'b1;
              end
            end else begin
              {r_dp, r_dn} <= SE0;
`ifdef USB_REPLAY_UNDERRUN_CNT_EN
              if (r_underrun_cnt != '1) r_underrun_cnt <= r_underrun_cnt + 16'd1;
`endif
            end
          end else begin
            r_div_cnt <= r_div_cnt + 32'd1;
          end
        end
        PAUSE: begin
          if (w_bus_free) r_state <= PLAY;
        end
        DONE: begin
          r_state <= DONE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_usb_replay_ctrl.sv
// tb_usb_replay_ctrl: two controllers (DIV=1 and DIV=4, ATTACH_CYC=8) driven by
// shared pull-up/oeb/reset and separate byte sources, checked every cycle
// against a sample-schedule model plus hand-computed literal points.
module tb_usb_replay_ctrl;

  localparam int unsigned ATT   = 8;
  localparam int unsigned DEPTH = 16;
  localparam int M_IDLE = 0, M_ATTACH = 1, M_PLAY = 2, M_PAUSE = 3, M_DONE = 4;

  logic clk_samp = 1'b0;
  always #5 clk_samp = ~clk_samp;

  logic             RSTB = 1'b1;
  logic             pu   = 1'b0;
  logic [1:0]       oeb  = 2'b11;
  logic [1:0][7:0]  sd   = '0;
  logic [1:0]       sv   = '0;
  logic [1:0]       sl   = '0;
  logic [1:0]       rdy, dp, dn, dpoe, dnoe, done;
  logic [1:0][31:0] cnt;
`ifdef USB_REPLAY_UNDERRUN_CNT_EN
  logic [1:0][15:0] und;
`endif

  usb_replay_ctrl #(.FIFO_DEPTH(DEPTH), .ATTACH_CYC(ATT), .DIV(1)) u_dut_div1 (
    .clk_samp(clk_samp), .RSTB(RSTB), .pu_i(pu), .dut_oeb_i(oeb),
    .src_data_i(sd[0]), .src_valid_i(sv[0]), .src_last_i(sl[0]), .src_ready_o(rdy[0]),
    .dp_o(dp[0]), .dn_o(dn[0]), .dp_oe_o(dpoe[0]), .dn_oe_o(dnoe[0]),
    .done_o(done[0]), .sample_cnt_o(cnt[0])
`ifdef USB_REPLAY_UNDERRUN_CNT_EN
    , .underrun_cnt_o(und[0])
`endif
  );

  usb_replay_ctrl #(.FIFO_DEPTH(DEPTH), .ATTACH_CYC(ATT), .DIV(4)) u_dut_div4 (
    .clk_samp(clk_samp), .RSTB(RSTB), .pu_i(pu), .dut_oeb_i(oeb),
    .src_data_i(sd[1]), .src_valid_i(sv[1]), .src_last_i(sl[1]), .src_ready_o(rdy[1]),
    .dp_o(dp[1]), .dn_o(dn[1]), .dp_oe_o(dpoe[1]), .dn_oe_o(dnoe[1]),
    .done_o(done[1]), .sample_cnt_o(cnt[1])
`ifdef USB_REPLAY_UNDERRUN_CNT_EN
    , .underrun_cnt_o(und[1])
`endif
  );

  int errors = 0;
  int checks = 0;

  // byte sources: list of {last, data}, consumed in order
  logic [8:0]  src_list [2][32];
  int          src_n [2] = '{0, 0};
  int          src_i [2] = '{0, 0};

  // model: mode, attach age, play ticks, ring buffer of samples, outputs
  int          m_mode [2];
  int unsigned m_age [2];
  int unsigned m_ticks [2];
  logic [2:0]  m_buf [2][DEPTH];
  int          m_head [2];
  int          m_size [2];
  logic [1:0]  m_line [2];
  logic [31:0] m_cnt [2];
  logic [15:0] m_und [2];
  logic        m_last_seen [2];
  logic        m_valid = 1'b0;

  function automatic logic m_ready(input int k);
    return (m_size[k] < int'(DEPTH)) && (m_mode[k] != M_DONE) && !m_last_seen[k];
  endfunction

  task automatic model_step(input int k, input int unsigned d);
    logic       take;
    logic [2:0] e;
    take = sv[k] && m_ready(k);
    if (RSTB) begin
      m_mode[k] = M_IDLE; m_age[k] = 0; m_ticks[k] = 0;
      m_head[k] = 0; m_size[k] = 0; m_line[k] = 2'b00;
      m_cnt[k] = 0; m_und[k] = 0; m_last_seen[k] = 1'b0;
      src_i[k] = src_n[k];
      return;
    end
    case (m_mode[k])
      M_IDLE: if (pu) begin m_mode[k] = M_ATTACH; m_age[k] = 0; end
      M_ATTACH: begin
        if (!pu) m_mode[k] = M_IDLE;
        else begin
          m_age[k]++;
          if (m_age[k] == ATT) begin m_mode[k] = M_PLAY; m_ticks[k] = 0; end
        end
      end
      M_PLAY: begin
        if (!pu) m_mode[k] = M_IDLE;
        else if (oeb != 2'b11) m_mode[k] = M_PAUSE;
        else begin
          m_ticks[k]++;
          if (m_ticks[k] % d == 0) begin
            if (m_size[k] > 0) begin
              e = m_buf[k][m_head[k]];
              m_head[k] = (m_head[k] + 1) % DEPTH;
              m_size[k]--;
              m_line[k] = e[1:0];
              m_cnt[k]++;
              if (e[2]) m_mode[k] = M_DONE;
            end else begin
              m_line[k] = 2'b00;
              if (m_und[k] != 16'hFFFF) m_und[k]++;
            end
          end
        end
      end
      M_PAUSE: if (oeb == 2'b11) m_mode[k] = M_PLAY;
      default: ;
    endcase
    if (take) begin
      m_buf[k][(m_head[k] + m_size[k]) % DEPTH] = {sl[k], sd[k][1:0]};
      m_size[k]++;
      if (sl[k]) m_last_seen[k] = 1'b1;
      src_i[k]++;
    end
  endtask

  // advance the model on each edge, then present the next source byte
  always @(posedge clk_samp) begin
    model_step(0, 1);
    model_step(1, 4);
    if (RSTB) m_valid = 1'b1;
    #2;
    for (int k = 0; k < 2; k++) begin
      sv[k] = (src_i[k] < src_n[k]);
      sd[k] = (src_i[k] < src_n[k]) ? {6'b0, src_list[k][src_i[k]][1:0]} : 8'h00;
      sl[k] = (src_i[k] < src_n[k]) ? src_list[k][src_i[k]][8] : 1'b0;
    end
  end

  // compare both DUTs with the model mid-cycle
  always @(negedge clk_samp) begin
    if (m_valid) begin
      for (int k = 0; k < 2; k++) begin
        logic [37:0] exp_v, got_v;
        exp_v = {m_ready(k), m_line[k], (m_mode[k] == M_PLAY) && oeb[1],
                 (m_mode[k] == M_PLAY) && oeb[0], m_mode[k] == M_DONE, m_cnt[k]};
        got_v = {rdy[k], dp[k], dn[k], dpoe[k], dnoe[k], done[k], cnt[k]};
        checks++;
        if (got_v !== exp_v) begin
          errors++;
          $display("FAIL model_cmp dut%0d t=%0t got{rdy,dp,dn,dpoe,dnoe,done,cnt}=%h required=%h",
                   k, $time, got_v, exp_v);
        end
`ifdef USB_REPLAY_UNDERRUN_CNT_EN
        checks++;
        if (und[k] !== m_und[k]) begin
          errors++;
          $display("FAIL model_und dut%0d t=%0t got=%0d required=%0d", k, $time, und[k], m_und[k]);
        end
`endif
      end
    end
  end

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp_v);
    checks++;
    if (got !== exp_v) begin
      errors++;
      $display("FAIL %s got=%h required=%h", nm, got, exp_v);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk_samp);
      #1;
    end
  endtask

  task automatic add(input int k, input logic [7:0] b, input logic last);
    src_list[k][src_n[k]] = {last, b};
    src_n[k]++;
  endtask

  task automatic do_reset();
    RSTB = 1'b1; pu = 1'b0; oeb = 2'b11;
    tick(2);
    RSTB = 1'b0;
  endtask

  task automatic add_both8(input logic last_on_final);
    logic [7:0] seq [8];
    seq = '{8'h01, 8'h02, 8'h03, 8'h01, 8'h02, 8'h03, 8'h01, 8'h02};
    for (int i = 0; i < 8; i++) begin
      add(0, seq[i], last_on_final && (i == 7));
      add(1, seq[i], last_on_final && (i == 7));
    end
  endtask

  initial begin
    // reset values
    do_reset();
    chk("rst_ready", {31'b0, rdy[0]}, 32'd1);
    chk("rst_line", {30'b0, dp[0], dn[0]}, 32'd0);
    chk("rst_oe", {30'b0, dpoe[0], dnoe[0]}, 32'd0);
    chk("rst_done", {31'b0, done[0]}, 32'd0);
    chk("rst_cnt", cnt[0], 32'd0);

    // basic playback, DIV=1 (dut0) and DIV=4 hold (dut1)
    add(0, 8'h02, 1'b0); add(0, 8'h01, 1'b0); add(0, 8'h03, 1'b1);
    add(1, 8'h02, 1'b0); add(1, 8'h01, 1'b0); add(1, 8'h03, 1'b0); add(1, 8'h02, 1'b1);
    tick(6);
    pu = 1'b1;
    for (int i = 1; i <= 26; i++) begin
      tick(1);
      case (i)
        9:  begin chk("t1_oe_play", {30'b0, dpoe[0], dnoe[0]}, 32'd3);
                  chk("t1_se0_first", {30'b0, dp[0], dn[0]}, 32'd0); end
        10: begin chk("t1_s1", {30'b0, dp[0], dn[0]}, 32'd2); chk("t1_c1", cnt[0], 32'd1); end
        11: chk("t1_s2", {30'b0, dp[0], dn[0]}, 32'd1);
        12: begin chk("t1_s3", {30'b0, dp[0], dn[0]}, 32'd3); chk("t1_cnt", cnt[0], 32'd3);
                  chk("t1_done", {31'b0, done[0]}, 32'd1);
                  chk("t1_oe_done", {30'b0, dpoe[0], dnoe[0]}, 32'd0); end
        13: chk("d4_s1_start", {30'b0, dp[1], dn[1]}, 32'd2);
        16: begin chk("d4_s1_hold", {30'b0, dp[1], dn[1]}, 32'd2); chk("d4_c1", cnt[1], 32'd1); end
        17: begin chk("d4_s2", {30'b0, dp[1], dn[1]}, 32'd1); chk("d4_c2", cnt[1], 32'd2); end
        25: begin chk("d4_s4", {30'b0, dp[1], dn[1]}, 32'd2); chk("d4_cnt", cnt[1], 32'd4);
                  chk("d4_done", {31'b0, done[1]}, 32'd1); end
        default: ;
      endcase
    end

    // DUT drives D- for 5 cycles mid-stream
    do_reset();
    add_both8(1'b1);
    tick(10);
    pu = 1'b1;
    tick(11);
    chk("p_pre_cnt", cnt[0], 32'd2);
    oeb = 2'b10;
    #1;
    chk("p_oe_same_cycle", {30'b0, dpoe[0], dnoe[0]}, 32'd2);
    tick(5);
    chk("p_frozen_cnt", cnt[0], 32'd2);
    oeb = 2'b11;
    tick(1);
    chk("p_resume_oe", {30'b0, dpoe[0], dnoe[0]}, 32'd3);
    chk("p_resume_cnt", cnt[0], 32'd2);
    tick(1);
    chk("p_next_byte", {30'b0, dp[0], dn[0]}, 32'd3);
    chk("p_next_cnt", cnt[0], 32'd3);
    tick(60);
    chk("p_all_d1", cnt[0], 32'd8);
    chk("p_all_d4", cnt[1], 32'd8);

    // source stall: three underruns on dut0
    do_reset();
    add(0, 8'h01, 1'b0); add(1, 8'h01, 1'b0);
    tick(2);
    pu = 1'b1;
    tick(10);
    chk("u_first", {30'b0, dp[0], dn[0]}, 32'd1);
    tick(1);
    chk("u_se0", {30'b0, dp[0], dn[0]}, 32'd0);
    tick(1);
    add(0, 8'h02, 1'b1); add(1, 8'h02, 1'b1);
    tick(1);
    chk("u_cnt_hold", cnt[0], 32'd1);
`ifdef USB_REPLAY_UNDERRUN_CNT_EN
    chk("u_und3", {16'b0, und[0]}, 32'd3);
`endif
    tick(1);
    chk("u_resume", {30'b0, dp[0], dn[0]}, 32'd2);
    chk("u_done", {31'b0, done[0]}, 32'd1);
    tick(6);

    // pull-up drop mid-PLAY and re-attach
    do_reset();
    add(0, 8'h01, 1'b0); add(0, 8'h02, 1'b0); add(0, 8'h03, 1'b1);
    add(1, 8'h01, 1'b0); add(1, 8'h02, 1'b0); add(1, 8'h03, 1'b1);
    tick(4);
    pu = 1'b1;
    tick(10);
    chk("pu_first", {30'b0, dp[0], dn[0]}, 32'd1);
    pu = 1'b0;
    tick(1);
    chk("pu_drop_oe", {30'b0, dpoe[0], dnoe[0]}, 32'd0);
    chk("pu_drop_cnt", cnt[0], 32'd1);
    tick(3);
    pu = 1'b1;
    tick(9);
    chk("pu_reattach_wait", cnt[0], 32'd1);
    tick(1);
    chk("pu_retained", {30'b0, dp[0], dn[0]}, 32'd2);
    chk("pu_cnt2", cnt[0], 32'd2);
    tick(3);

    // reset during PLAY with five samples still buffered in dut0
    do_reset();
    add_both8(1'b0);
    tick(10);
    pu = 1'b1;
    tick(12);
    chk("r_pre_cnt", cnt[0], 32'd3);
    RSTB = 1'b1;
    tick(1);
    chk("r_cnt", cnt[0], 32'd0);
    chk("r_line", {30'b0, dp[0], dn[0]}, 32'd0);
    chk("r_oe", {30'b0, dpoe[0], dnoe[0]}, 32'd0);
    chk("r_ready", {31'b0, rdy[0]}, 32'd1);
    RSTB = 1'b0;
    tick(15);
    chk("r_flushed_cnt", cnt[0], 32'd0);
    chk("r_flushed_line", {30'b0, dp[0], dn[0]}, 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
